// File: rtl/rbm_host_sequencer_if.sv
// ---------------------------------------------------------------------------
// rbm_host_sequencer_if
// Bundles every non-clock signal between the host sequencer, the pixel
// source, the Main RBM core and the result consumer.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. A valid, once raised, holds its payload stable until the
// transfer. Ready may be high with valid low, which has no effect.
//   pixel stream : pixel_valid / pixel_ready, payload pixel_in
//   result       : result_valid / result_ready, payload label + max_score
//
// Modports
//   master : the sequencer (drives pixel_ready, core_* controls, results)
//   slave  : the environment (pixel source, Main core, result consumer)
// ---------------------------------------------------------------------------
interface rbm_host_sequencer_if #(
   parameter int input_dim   = 784,
   parameter int output_dim  = 10,
   parameter int w_bitlength = 12,
   parameter int label_bits  = 4
);
   logic                              pixel_in;
   logic                              pixel_valid;
   logic                              pixel_ready;
   logic                              core_reset;
   logic                              core_data_valid;
   logic [input_dim-1:0]              core_input_port;
   logic [output_dim*w_bitlength-1:0] core_output_port;
   logic                              core_finish;
   logic [label_bits-1:0]             label;
   logic [w_bitlength-1:0]            max_score;
   logic                              result_valid;
   logic                              result_ready;
   logic                              busy;

   modport master (
      input  pixel_in, pixel_valid, core_output_port, core_finish, result_ready,
      output pixel_ready, core_reset, core_data_valid, core_input_port,
             label, max_score, result_valid, busy
   );

   modport slave (
      output pixel_in, pixel_valid, core_output_port, core_finish, result_ready,
      input  pixel_ready, core_reset, core_data_valid, core_input_port,
             label, max_score, result_valid, busy
   );
endinterface

// File: rtl/rbm_host_sequencer.sv
// ---------------------------------------------------------------------------
// rbm_host_sequencer
// Host-side driver for the Main RBM core. Assembles a serial pixel stream
// into the packed input image, pulses the core reset, runs the core until
// its finish rises, captures the packed scores and performs a one-score-per-
// cycle signed argmax, returning the winning label over a valid/ready
// handshake.
//
// Ports
//   clock     : single clock, rising edge
//   reset     : synchronous, active-low
//   bus       : rbm_host_sequencer_if.master (pixel stream, core, result)
//   dbg_state : current FSM state encoding (IDLE=0 LOAD=1 CRST=2 RUN=3
//               SCAN=4 RESULT=5)
// ---------------------------------------------------------------------------
module rbm_host_sequencer #(
   parameter int input_dim   = 784,
   parameter int output_dim  = 10,
   parameter int w_bitlength = 12,
   parameter int label_bits  = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   rbm_host_sequencer_if.master        bus,
   output logic [2:0]                  dbg_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CRST   = 3'd2,
      RUN    = 3'd3,
      SCAN   = 3'd4,
      RESULT = 3'd5
   } state_t;

   localparam int cnt_w = (input_dim > 1) ? $clog2(input_dim) : 1;

   state_t                            state;
   state_t                            state_nxt;
   logic [cnt_w-1:0]                  cnt;
   logic [input_dim-1:0]              image;
   logic [1:0]                        crst_cnt;
   logic                              finish_q;
   logic [output_dim*w_bitlength-1:0] scores;
   logic [label_bits-1:0]             idx;
   logic [label_bits-1:0]             label_r;
   logic [w_bitlength-1:0]            max_r;
   logic [w_bitlength-1:0]            cur_score;
   logic                              pixel_xfer;
   logic                              last_pixel;
   logic                              finish_edge;
   logic                              scan_last;
   logic                              run_entry;

   // pixel_ready is high exactly in LOAD, so a transfer is LOAD && valid.
   assign pixel_xfer  = (state == LOAD) && bus.pixel_valid;
   assign last_pixel  = pixel_xfer && (cnt == cnt_w'(input_dim - 1));
   assign finish_edge = (state == RUN) && bus.core_finish && !finish_q;
   assign scan_last   = (state == SCAN) && (idx == label_bits'(output_dim - 1));
   assign run_entry   = (state == CRST) && (state_nxt == RUN);

   // Score currently under inspection by the argmax scan.
   always_comb begin
      cur_score = '0;
      for (int j = 0; j < output_dim; j++) begin
         if (idx == label_bits'(j)) begin
            cur_score = scores[j*w_bitlength +: w_bitlength];
         end
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and Moore-decoded control outputs.
   always_comb begin
      state_nxt           = state;
      bus.pixel_ready     = 1'b0;
      bus.core_reset      = 1'b0;
      bus.core_data_valid = 1'b0;
      bus.result_valid    = 1'b0;
      bus.busy            = 1'b1;
      case (state)
         IDLE: begin
            bus.core_reset = 1'b1;
            state_nxt      = LOAD;
         end
         LOAD: begin
            bus.pixel_ready = 1'b1;
            bus.busy        = 1'b0;
            if (last_pixel) state_nxt = CRST;
         end
         CRST: begin
            bus.core_reset = 1'b1;
            if (crst_cnt == 2'd1) state_nxt = RUN;
         end
         RUN: begin
            bus.core_data_valid = 1'b1;
            if (finish_edge) state_nxt = SCAN;
         end
         SCAN: begin
            if (scan_last) state_nxt = RESULT;
         end
         RESULT: begin
            bus.result_valid = 1'b1;
            bus.busy         = 1'b0;
            if (bus.result_ready) state_nxt = LOAD;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: image assembly, core-reset timer, finish edge detect,
   // score capture and argmax.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt      <= '0;
         image    <= '0;
         crst_cnt <= 2'd0;
         finish_q <= 1'b1;
         scores   <= '0;
         idx      <= '0;
         label_r  <= '0;
         max_r    <= '0;
      end else begin
         // Forcing finish_q high on RUN entry means a finish that is already
         // high must fall and rise again before it counts.
         finish_q <= run_entry ? 1'b1 : bus.core_finish;

         if (pixel_xfer) begin
            image[cnt] <= bus.pixel_in;
            cnt        <= last_pixel ? '0 : cnt + 1'b1;
         end

         crst_cnt <= (state == CRST) ? crst_cnt + 2'd1 : 2'd0;

         if (finish_edge) begin
            scores <= bus.core_output_port;
            idx    <= '0;
         end

         // Strictly-greater replacement keeps the lowest index on ties.
         if (state == SCAN) begin
            if ((idx == '0) || ($signed(cur_score) > $signed(max_r))) begin
               label_r <= idx;
               max_r   <= cur_score;
            end
            idx <= idx + 1'b1;
         end
      end
   end

   assign bus.core_input_port = image;
   assign bus.label           = label_r;
   assign bus.max_score       = max_r;
   assign dbg_state           = state;

endmodule

// File: tb/tb_rbm_host_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rbm_host_sequencer
// Directed bench for rbm_host_sequencer with a small behavioural Main core:
// once data_valid is seen the model raises finish after a few cycles and
// holds it until core_reset. Scores are presented on core_output_port from
// model_scores. Expected {label, max_score} pairs go into exp_q when an image
// is started and are popped when the result handshake occurs.
// ---------------------------------------------------------------------------
module tb_rbm_host_sequencer;
   localparam int input_dim   = 8;
   localparam int output_dim  = 4;
   localparam int w_bitlength = 12;
   localparam int label_bits  = 4;
   localparam int res_w       = label_bits + w_bitlength;
   localparam int sw          = output_dim * w_bitlength;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_CRST = 3'd2;

   // ---------------- clock / reset ----------------
   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] dbg_state;

   always #5 clock = ~clock;

   rbm_host_sequencer_if #(
      .input_dim(input_dim), .output_dim(output_dim),
      .w_bitlength(w_bitlength), .label_bits(label_bits)
   ) bus ();

   rbm_host_sequencer #(
      .input_dim(input_dim), .output_dim(output_dim),
      .w_bitlength(w_bitlength), .label_bits(label_bits)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- behavioural Main ----------------
   logic          model_en     = 1'b0;
   logic          force_finish = 1'b0;
   logic          m_finish     = 1'b0;
   logic [2:0]    m_cnt        = 3'd0;
   logic [sw-1:0] model_scores = '0;

   always @(posedge clock) begin
      if (bus.core_reset || !model_en) begin
         m_cnt    <= 3'd0;
         m_finish <= 1'b0;
      end else if (bus.core_data_valid && !m_finish) begin
         if (m_cnt == 3'd3) m_finish <= 1'b1;
         else               m_cnt    <= m_cnt + 3'd1;
      end
   end

   assign bus.core_finish      = m_finish | force_finish;
   assign bus.core_output_port = model_scores;

   // ---------------- scoreboard ----------------
   int               checks = 0;
   int               errors = 0;
   logic [res_w-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference argmax: find the maximum value, then the first index holding it.
   function automatic logic [res_w-1:0] ref_argmax(input logic [sw-1:0] s);
      logic signed [w_bitlength-1:0] best;
      int                            pos;
      best = s[w_bitlength-1:0];
      for (int j = 1; j < output_dim; j++) begin
         if ($signed(s[j*w_bitlength +: w_bitlength]) > best) best = s[j*w_bitlength +: w_bitlength];
      end
      pos = 0;
      for (int j = output_dim - 1; j >= 0; j--) begin
         if (s[j*w_bitlength +: w_bitlength] == best) pos = j;
      end
      return {label_bits'(pos), best};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_image(input logic [sw-1:0] s, input logic [res_w-1:0] expv);
      model_scores = s;
      exp_q.push_back(expv);
   endtask

   task automatic load_image(input logic [input_dim-1:0] img);
      for (int k = 0; k < input_dim; k++) begin
         bus.pixel_valid = 1'b1;
         bus.pixel_in    = img[k];
         tick();
      end
      bus.pixel_valid = 1'b0;
      bus.pixel_in    = 1'b0;
   endtask

   task automatic wait_result();
      int n;
      n = 0;
      while (!bus.result_valid && n < 60) begin
         tick();
         n++;
      end
      check("result_timeout", bus.result_valid, 1);
   endtask

   task automatic take_result();
      logic [res_w-1:0] e;
      check("sb_pending", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("label", bus.label, e[res_w-1 -: label_bits]);
         check("max_score", bus.max_score, e[w_bitlength-1:0]);
      end
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
      check("post_hs_rv", bus.result_valid, 0);
      check("post_hs_pready", bus.pixel_ready, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [sw-1:0] rs;
      int            n;

      bus.pixel_in     = 1'b0;
      bus.pixel_valid  = 1'b0;
      bus.result_ready = 1'b0;

      // Reset held for 3 cycles.
      reset = 1'b0;
      repeat (3) begin
         tick();
         check("rst_core_reset", bus.core_reset, 1);
         check("rst_pixel_ready", bus.pixel_ready, 0);
         check("rst_data_valid", bus.core_data_valid, 0);
         check("rst_result_valid", bus.result_valid, 0);
      end
      check("rst_input_port", bus.core_input_port, 0);
      check("rst_label", bus.label, 0);
      check("rst_max", bus.max_score, 0);
      reset = 1'b1;
      check("idle_state", dbg_state, S_IDLE);
      tick();
      check("load_pready", bus.pixel_ready, 1);
      check("load_core_reset", bus.core_reset, 0);
      check("load_busy", bus.busy, 0);

      // Image A: load timing, scan timing, backpressure.
      model_en = 1'b1;
      start_image({12'h010, 12'h07F, 12'hFFE, 12'h005}, {4'd2, 12'h07F});
      load_image(8'b01001101);
      check("a_crst1_reset", bus.core_reset, 1);
      check("a_crst1_pready", bus.pixel_ready, 0);
      check("a_crst1_busy", bus.busy, 1);
      check("a_image", bus.core_input_port, 8'h4D);
      tick();
      check("a_crst2_reset", bus.core_reset, 1);
      check("a_crst2_dv", bus.core_data_valid, 0);
      tick();
      check("a_run_reset", bus.core_reset, 0);
      check("a_run_dv", bus.core_data_valid, 1);
      n = 0;
      while (bus.core_data_valid && n < 60) begin
         tick();
         n++;
      end
      check("a_finish_timeout", bus.core_data_valid, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("a_scan_rv", bus.result_valid, 0);
      end
      tick();
      check("a_rv_rise", bus.result_valid, 1);
      repeat (5) begin
         tick();
         check("bp_rv", bus.result_valid, 1);
         check("bp_label", bus.label, 2);
         check("bp_pready", bus.pixel_ready, 0);
      end
      take_result();

      // Image B: ties and negatives; finish high during LOAD; pixels offered
      // while not ready are dropped.
      start_image({12'hFFF, 12'h020, 12'h020, 12'hF00}, {4'd1, 12'h020});
      force_finish = 1'b1;
      load_image(8'hB2);
      force_finish = 1'b0;
      check("b_state_crst", dbg_state, S_CRST);
      bus.pixel_valid = 1'b1;
      bus.pixel_in    = 1'b1;
      tick();
      tick();
      bus.pixel_valid = 1'b0;
      bus.pixel_in    = 1'b0;
      check("b_image_held", bus.core_input_port, 8'hB2);
      wait_result();
      take_result();

      // Image C: all negative, result_ready held high beforehand.
      bus.result_ready = 1'b1;
      start_image({12'hF10, 12'hF08, 12'hF10, 12'hF00}, {4'd1, 12'hF10});
      load_image(8'h5A);
      wait_result();
      take_result();

      // Image D: finish stuck high on entry to RUN.
      model_en = 1'b0;
      for (int j = 0; j < output_dim; j++) rs[j*w_bitlength +: w_bitlength] = 12'($urandom_range(0, 4095));
      start_image(rs, ref_argmax(rs));
      load_image(8'h3C);
      force_finish = 1'b1;
      tick();
      tick();
      check("d_run_dv", bus.core_data_valid, 1);
      repeat (4) begin
         tick();
         check("d_stuck_no_capture", bus.core_data_valid, 1);
      end
      force_finish = 1'b0;
      tick();
      check("d_low_dv", bus.core_data_valid, 1);
      force_finish = 1'b1;
      tick();
      force_finish = 1'b0;
      check("d_capture", bus.core_data_valid, 0);
      wait_result();
      take_result();

      // Reset during a partial load, then during RUN.
      for (int k = 0; k < 3; k++) begin
         bus.pixel_valid = 1'b1;
         bus.pixel_in    = 1'b1;
         tick();
      end
      bus.pixel_valid = 1'b0;
      reset = 1'b0;
      tick();
      check("rl_state", dbg_state, S_IDLE);
      check("rl_image_clr", bus.core_input_port, 0);
      reset = 1'b1;
      tick();
      load_image(8'hC3);
      check("rl_cnt_restart", dbg_state, S_CRST);
      check("rl_image", bus.core_input_port, 8'hC3);
      tick();
      tick();
      check("rr_run_dv", bus.core_data_valid, 1);
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rr_dv", bus.core_data_valid, 0);
      check("rr_core_reset", bus.core_reset, 1);
      check("rr_state", dbg_state, S_IDLE);
      check("rr_rv", bus.result_valid, 0);
      reset = 1'b1;
      tick();
      check("rr_load", dbg_state, S_LOAD);

      // Image F: random scores after recovery.
      model_en = 1'b1;
      for (int j = 0; j < output_dim; j++) rs[j*w_bitlength +: w_bitlength] = 12'($urandom_range(0, 4095));
      start_image(rs, ref_argmax(rs));
      load_image(8'h96);
      check("f_image", bus.core_input_port, 8'h96);
      wait_result();
      take_result();

      check("sb_drain", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rbm_host_sequencer.md
# rbm_host_sequencer

Host-side driver for the `Main` RBM core. It accepts a serial 1-bit pixel stream, assembles the `input_dim`-bit input vector, resets and starts the core, and captures the packed `output_dim` scores when `finish` rises. It then runs a one-element-per-cycle argmax over the scores and returns the winning label through a valid/ready handshake. It replaces the simulation-only stimulus and monitor logic with synthesizable RTL placed in front of `Main`.

## Interface
- `input_dim`, 784, pixels per image; width of `core_input_port`.
- `output_dim`, 10, number of class scores.
- `w_bitlength`, 12, width of one score (signed two's complement).
- `label_bits`, 4, width of `label`; must satisfy 2^`label_bits` >= `output_dim`.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low.
- `pixel_in`  in  1  pixel bit.
- `pixel_valid`  in  1  `pixel_in` is valid.
- `pixel_ready`  out  1  sequencer accepts a pixel this cycle.
- `core_reset`  out  1  active-high reset to `Main`.
- `core_data_valid`  out  1  drives `Main` `data_valid`.
- `core_input_port`  out  `input_dim`  packed image; pixel k at bit k.
- `core_output_port`  in  `output_dim`*`w_bitlength`  packed scores; score j at bits [j*w+w-1 : j*w].
- `core_finish`  in  1  `Main` finish.
- `label`  out  `label_bits`  argmax index.
- `max_score`  out  `w_bitlength`  score at `label`.
- `result_valid`  out  1  `label` and `max_score` are valid.
- `result_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in every state except `LOAD` and `RESULT`.

## Operation
- States: `IDLE`, `LOAD`, `CRST`, `RUN`, `SCAN`, `RESULT`.
- Reset (`reset`=0 at an edge) forces state `IDLE`. It clears the pixel counter, `core_input_port`, `label`, `max_score`, `result_valid`, `core_data_valid` and `pixel_ready` to 0, and sets `core_reset` to 1. This applies in any state; a partial image or an in-flight result is discarded.
- `IDLE`: lasts one cycle with `core_reset`=1, then goes to `LOAD`.
- `LOAD`:
  - `pixel_ready`=1 and `core_reset`=0.
  - A transfer occurs when `pixel_valid`&&`pixel_ready`. The pixel is written to bit `cnt` and `cnt` increments.
  - The transfer with `cnt`=`input_dim`-1 moves the state to `CRST` and clears `cnt`.
- `CRST`: `core_reset`=1 for exactly 2 cycles (2-bit counter), then goes to `RUN`.
- `RUN`:
  - `core_data_valid`=1 and `core_input_port` is held stable.
  - `finish_q` registers `core_finish` every cycle and is forced to 1 on entry to `RUN`. This prevents a stale high `finish` from triggering.
  - A finish edge is `core_finish`=1 && `finish_q`=0 while in `RUN`. On that edge: capture `core_output_port` into a score register, drop `core_data_valid`, and go to `SCAN` with `idx`=0.
  - `core_finish` is ignored in every other state.
- `SCAN`:
  - Each cycle compares score[`idx`] against `max_score` using a signed compare.
  - At `idx`=0 the score is loaded unconditionally.
  - For later indices, a strictly greater score replaces `label`/`max_score`; ties keep the lower index.
  - After `idx`=`output_dim`-1 the state goes to `RESULT`.
- `RESULT`:
  - `result_valid`=1, with `label`/`max_score` stable.
  - On `result_valid`&&`result_ready` the state goes to `LOAD`. `label`/`max_score` hold their values until the next `SCAN`.
- `core_input_port` is not cleared between images; every bit is overwritten by the next load.

## Timing
- Pixel throughput: 1 pixel/cycle; `pixel_ready` deasserts the cycle after the final transfer.
- Last pixel transferred at edge L:
  - `core_reset` is high for the cycles following edges L and L+1.
  - `core_data_valid` rises after edge L+2.
- Finish edge sampled at edge E:
  - `core_data_valid` is low after E.
  - The scan compares occur at edges E+1 … E+`output_dim`.
  - `result_valid` goes high after E+`output_dim`.
- Result handshake at edge R: `result_valid`=0 and `pixel_ready`=1 after R.
- `pixel_valid` while `pixel_ready`=0 is ignored; no buffering.
- `result_ready` held high while `result_valid`=0 has no effect.
- There is no timeout: `RUN` waits indefinitely for `finish`.

## Test plan
Bench parameters: `input_dim`=8, `output_dim`=4, `w_bitlength`=12, with a behavioural `Main` model.
- Reset and start-up: hold `reset`=0 for 3 cycles, then release -> after release `core_reset`=1 for one cycle (`IDLE`), then `pixel_ready`=1. All other outputs are 0 throughout.
- Load: stream pixels 1,0,1,1,0,0,1,0 back-to-back -> `core_input_port`=8'b01001101. `core_reset` is high for 2 cycles, then `core_data_valid`=1.
- Argmax: `finish` rises with scores {12'h005, 12'hFFE, 12'h07F, 12'h010} -> after 4 cycles `result_valid`=1, `label`=2, `max_score`=12'h07F.
- Ties and negatives: scores {12'hF00, 12'h020, 12'h020, 12'hFFF} -> `label`=1, `max_score`=12'h020. All-negative scores {12'hF00, 12'hF10, 12'hF08, 12'hF10} -> `label`=1.
- Backpressure: hold `result_ready`=0 for 5 cycles -> `result_valid` and `label` stay stable and `pixel_ready`=0. Raise `result_ready` -> `pixel_ready`=1 the next cycle.
- Robustness:
  - `core_finish` pulsed in `LOAD` -> ignored.
  - `core_finish` stuck high on entry to `RUN` -> no capture until it falls and rises again.
  - `reset`=0 asserted mid-`RUN` -> `IDLE`, `core_data_valid`=0, `core_reset`=1, pixel counter restarts at 0.
